// File: rtl/fir_mac_serial.sv
// Serial FIR: TAPS-deep delay line and writable coefficient bank, one multiplier iterated over TAPS cycles.
// Define FIR_SATURATE_EN to clamp the result to OUT_W bits instead of wrapping.
module fir_mac_serial #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 5,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data
);

  localparam int IDX_W = $clog2(TAPS);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t            state;
  logic [DATA_W-1:0] x [TAPS];
  logic [COEF_W-1:0] c [TAPS];
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  prod;
  logic [ACC_W-1:0]  acc_sum;
  logic [IDX_W-1:0]  idx;
  logic [OUT_W-1:0]  out_next;
  logic              accept;
  logic              coef_hit;

  assign accept   = in_valid && in_ready;
  assign coef_hit = coef_we && (state == S_IDLE) && (int'(coef_addr) < TAPS);
  assign prod     = ACC_W'(x[idx]) * ACC_W'(c[idx]);
  assign acc_sum  = acc + prod;

  // Narrowing of the final sum; any bits above OUT_W mean the result does not fit.
  always_comb begin
    out_next = OUT_W'(acc_sum);
`ifdef FIR_SATURATE_EN
    if ((acc_sum >> OUT_W) != '0) out_next = '1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      if (coef_hit) c[coef_addr] <= coef_wdata;
      if (accept) begin
        for (int k = TAPS - 1; k > 0; k--) x[k] <= x[k-1];
        x[0] <= in_data;
      end
    end
  end

  // The last MAC step registers the completed sum straight into out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      idx       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          if (idx == IDX_W'(TAPS - 1)) begin
            idx       <= '0;
            out_data  <= out_next;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
